// File: rtl/process_scheduler_if.sv
// Scheduler bus: run events from the control unit, process create/release
// requests, and the PC-load/status outputs towards the PC register.
interface process_scheduler_if #(
    parameter int NUM_PROC = 4,
    parameter int PC_W     = 32
);
    localparam int ID_W = $clog2(NUM_PROC);

    logic            troca_contexto;
    logic            fim_processo;
    logic            io_bloqueio;
    logic [PC_W-1:0] pc_salvo;
    logic            cria_valido;
    logic [ID_W-1:0] cria_id;
    logic [PC_W-1:0] cria_pc;
    logic            io_libera;
    logic [ID_W-1:0] io_libera_id;
    logic            carrega_pc;
    logic [PC_W-1:0] pc_novo;
    logic [ID_W-1:0] processo_atual;
    logic            ocioso;
    logic            cria_erro;
    logic [15:0]     trocas;

    modport master (
        output troca_contexto, fim_processo, io_bloqueio, pc_salvo,
               cria_valido, cria_id, cria_pc, io_libera, io_libera_id,
        input  carrega_pc, pc_novo, processo_atual, ocioso, cria_erro, trocas
    );

    modport slave (
        input  troca_contexto, fim_processo, io_bloqueio, pc_salvo,
               cria_valido, cria_id, cria_pc, io_libera, io_libera_id,
        output carrega_pc, pc_novo, processo_atual, ocioso, cria_erro, trocas
    );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: process table plus WAIT/SEARCH/LOAD/RUN FSM.
// Optional dispatch counter on trocas is built only when SCHED_STATS_EN is defined.
module process_scheduler #(
    parameter int NUM_PROC = 4,
    parameter int PC_W     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    process_scheduler_if.slave    bus
);
    localparam int ID_W = $clog2(NUM_PROC);
    localparam logic [ID_W-1:0] LAST_CHECK = ID_W'(NUM_PROC - 1);

    typedef enum logic [1:0] {E_FREE, E_READY, E_RUNNING, E_BLOCKED} ent_t;
    typedef enum logic [1:0] {S_WAIT, S_SEARCH, S_LOAD, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] idx_q, idx_d;
    logic [ID_W-1:0] cnt_q, cnt_d;
    ent_t            ent_q [NUM_PROC];
    ent_t            ent_d [NUM_PROC];
    logic [PC_W-1:0] pc_q  [NUM_PROC];
    logic [PC_W-1:0] pc_d  [NUM_PROC];

    logic            carrega_q, carrega_d;
    logic [PC_W-1:0] pc_novo_q, pc_novo_d;
    logic [ID_W-1:0] atual_q, atual_d;
    logic            ocioso_q, ocioso_d;
    logic            erro_q, erro_d;

    logic hit;
    logic run_ev;
    logic any_ready_d;

    assign hit    = (state_q == S_SEARCH) && (ent_q[idx_q] == E_READY);
    assign run_ev = (state_q == S_RUN) &&
                    (bus.fim_processo || bus.io_bloqueio || bus.troca_contexto);

    // Table updates are judged on pre-edge entry state, so no two writers can hit one slot.
    always_comb begin
        for (int i = 0; i < NUM_PROC; i++) begin
            ent_d[i] = ent_q[i];
            pc_d[i]  = pc_q[i];
        end
        if (bus.cria_valido && ent_q[bus.cria_id] == E_FREE) begin
            ent_d[bus.cria_id] = E_READY;
            pc_d[bus.cria_id]  = bus.cria_pc;
        end
        if (bus.io_libera && ent_q[bus.io_libera_id] == E_BLOCKED) begin
            ent_d[bus.io_libera_id] = E_READY;
        end
        if (hit) begin
            ent_d[idx_q] = E_RUNNING;
        end
        if (state_q == S_RUN) begin
            if (bus.fim_processo) begin
                ent_d[atual_q] = E_FREE;
            end else if (bus.io_bloqueio) begin
                ent_d[atual_q] = E_BLOCKED;
                pc_d[atual_q]  = bus.pc_salvo;
            end else if (bus.troca_contexto) begin
                ent_d[atual_q] = E_READY;
                pc_d[atual_q]  = bus.pc_salvo;
            end
        end
        any_ready_d = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (ent_d[i] == E_READY) any_ready_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (any_ready_d) begin
                    state_d = S_SEARCH;
                    idx_d   = atual_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_SEARCH: begin
                if (hit) begin
                    state_d = S_LOAD;
                end else if (cnt_q == LAST_CHECK) begin
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (run_ev) begin
                    state_d = S_SEARCH;
                    idx_d   = atual_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Outputs are registered: the hit edge loads them so they are valid during LOAD.
    always_comb begin
        carrega_d = hit;
        pc_novo_d = hit ? pc_q[idx_q] : pc_novo_q;
        atual_d   = hit ? idx_q : atual_q;
        ocioso_d  = (state_d == S_WAIT);
        erro_d    = bus.cria_valido && (ent_q[bus.cria_id] != E_FREE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_WAIT;
            idx_q     <= '0;
            cnt_q     <= '0;
            carrega_q <= 1'b0;
            pc_novo_q <= '0;
            atual_q   <= '0;
            ocioso_q  <= 1'b1;
            erro_q    <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++) begin
                ent_q[i] <= E_FREE;
                pc_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            carrega_q <= carrega_d;
            pc_novo_q <= pc_novo_d;
            atual_q   <= atual_d;
            ocioso_q  <= ocioso_d;
            erro_q    <= erro_d;
            for (int i = 0; i < NUM_PROC; i++) begin
                ent_q[i] <= ent_d[i];
                pc_q[i]  <= pc_d[i];
            end
        end
    end

    assign bus.carrega_pc     = carrega_q;
    assign bus.pc_novo        = pc_novo_q;
    assign bus.processo_atual = atual_q;
    assign bus.ocioso         = ocioso_q;
    assign bus.cria_erro      = erro_q;

`ifdef SCHED_STATS_EN
    logic [15:0] trocas_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            trocas_q <= '0;
        end else if (state_q == S_LOAD && trocas_q != 16'hFFFF) begin
            trocas_q <= trocas_q + 16'd1;
        end
    end

    assign bus.trocas = trocas_q;
`else
    assign bus.trocas = '0;
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: dispatches are predicted into a
// scoreboard queue when events are driven and popped when carrega_pc fires.
module tb_process_scheduler;
    localparam int NUM_PROC = 4;
    localparam int PC_W     = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    process_scheduler_if #(.NUM_PROC(NUM_PROC), .PC_W(PC_W)) bus ();

    process_scheduler #(.NUM_PROC(NUM_PROC), .PC_W(PC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  id;
    } disp_t;

    disp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;
    int n_disp   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_disp(input logic [31:0] pc, input logic [1:0] id);
        disp_t e;
        e.pc = pc;
        e.id = id;
        sb.push_back(e);
    endtask

    task automatic wait_dispatch(input string tag, input int exp_lat);
        int    n = 0;
        bit    seen = 1'b0;
        disp_t e;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (bus.carrega_pc === 1'b1) seen = 1'b1;
        end
        check({tag, " seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, n, exp_lat);
            check({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, " pc_novo"}, bus.pc_novo, e.pc);
                check({tag, " processo_atual"}, 32'(bus.processo_atual), 32'(e.id));
            end
            n_disp++;
            tick();
            check({tag, " pulse_end"}, 32'(bus.carrega_pc), 32'd0);
            check({tag, " ocioso_run"}, 32'(bus.ocioso), 32'd0);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, 32'(bus.carrega_pc), 32'd0);
        end
    endtask

    task automatic create(input string tag, input logic [1:0] id, input logic [31:0] pc,
                          input logic exp_err);
        bus.cria_valido = 1'b1;
        bus.cria_id     = id;
        bus.cria_pc     = pc;
        tick();
        bus.cria_valido = 1'b0;
        check({tag, " cria_erro"}, 32'(bus.cria_erro), 32'(exp_err));
    endtask

    task automatic run_event(input logic fim, input logic io, input logic troca,
                             input logic [31:0] pc);
        bus.fim_processo   = fim;
        bus.io_bloqueio    = io;
        bus.troca_contexto = troca;
        bus.pc_salvo       = pc;
        tick();
        bus.fim_processo   = 1'b0;
        bus.io_bloqueio    = 1'b0;
        bus.troca_contexto = 1'b0;
    endtask

    function automatic logic [31:0] exp_trocas(input int n);
`ifdef SCHED_STATS_EN
        return 32'(n);
`else
        return 32'(n) & 32'd0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.troca_contexto = 1'b0;
        bus.fim_processo   = 1'b0;
        bus.io_bloqueio    = 1'b0;
        bus.pc_salvo       = '0;
        bus.cria_valido    = 1'b0;
        bus.cria_id        = '0;
        bus.cria_pc        = '0;
        bus.io_libera      = 1'b0;
        bus.io_libera_id   = '0;
        tick();
        tick();
        check("rst carrega_pc", 32'(bus.carrega_pc), 32'd0);
        check("rst pc_novo", bus.pc_novo, 32'd0);
        check("rst processo_atual", 32'(bus.processo_atual), 32'd0);
        check("rst ocioso", 32'(bus.ocioso), 32'd1);
        check("rst cria_erro", 32'(bus.cria_erro), 32'd0);
        check("rst trocas", 32'(bus.trocas), 32'd0);
        reset = 1'b0;
        idle("idle after reset", 3);
        check("ocioso empty", 32'(bus.ocioso), 32'd1);

        // First dispatch: slot 0, search started at slot 1
        expect_disp(32'd301, 2'd0);
        create("create0", 2'd0, 32'd301, 1'b0);
        create("create1", 2'd1, 32'd400, 1'b0);
        wait_dispatch("disp301", 3);

        expect_disp(32'd400, 2'd1);
        run_event(1'b0, 1'b0, 1'b1, 32'd306);
        wait_dispatch("troca to 400", 1);

        expect_disp(32'd306, 2'd0);
        run_event(1'b0, 1'b0, 1'b1, 32'd405);
        wait_dispatch("troca to 306", 3);

        expect_disp(32'd405, 2'd1);
        run_event(1'b1, 1'b0, 1'b0, 32'd123);
        wait_dispatch("fim to 405", 1);

        // Slot 1 blocks with nothing else ready: full search, then WAIT
        run_event(1'b0, 1'b1, 1'b0, 32'd410);
        idle("io_bloqueio search", 4);
        check("ocioso after block", 32'(bus.ocioso), 32'd1);
        expect_disp(32'd410, 2'd1);
        bus.io_libera    = 1'b1;
        bus.io_libera_id = 2'd1;
        tick();
        bus.io_libera    = 1'b0;
        wait_dispatch("io_libera 410", 4);

        // fim + troca + recreate in one edge
        bus.cria_valido = 1'b1;
        bus.cria_id     = 2'd1;
        bus.cria_pc     = 32'd777;
        run_event(1'b1, 1'b0, 1'b1, 32'd999);
        bus.cria_valido = 1'b0;
        check("same-edge cria_erro", 32'(bus.cria_erro), 32'd1);
        idle("fim+troca search", 1);
        check("cria_erro one pulse", 32'(bus.cria_erro), 32'd0);
        idle("fim+troca search", 3);
        check("ocioso after fim", 32'(bus.ocioso), 32'd1);
        expect_disp(32'd500, 2'd1);
        create("recreate1", 2'd1, 32'd500, 1'b0);
        wait_dispatch("disp500", 4);

        // Create on a READY slot is rejected and leaves the entry intact
        create("create2", 2'd2, 32'd600, 1'b0);
        create("create2 dup", 2'd2, 32'd700, 1'b1);
        expect_disp(32'd600, 2'd2);
        run_event(1'b0, 1'b0, 1'b1, 32'd510);
        wait_dispatch("disp600", 1);
        check("trocas before reset", 32'(bus.trocas), exp_trocas(n_disp));

        // Reset while the scheduler is searching
        run_event(1'b0, 1'b0, 1'b1, 32'd610);
        reset = 1'b1;
        tick();
        check("midrst carrega_pc", 32'(bus.carrega_pc), 32'd0);
        check("midrst ocioso", 32'(bus.ocioso), 32'd1);
        check("midrst processo_atual", 32'(bus.processo_atual), 32'd0);
        check("midrst pc_novo", bus.pc_novo, 32'd0);
        check("midrst trocas", 32'(bus.trocas), 32'd0);
        tick();
        reset = 1'b0;
        n_disp = 0;
        idle("after midrst", 8);
        check("ocioso after midrst", 32'(bus.ocioso), 32'd1);
        expect_disp(32'd900, 2'd1);
        create("create1 after rst", 2'd1, 32'd900, 1'b0);
        wait_dispatch("disp900", 1);
        check("trocas after rst", 32'(bus.trocas), exp_trocas(n_disp));
        check("scoreboard drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
